// File: rtl/pipe_ex2.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ex2
//  Purpose  : Four-stage register-register ALU pipeline (fetch, execute,
//             write-back, store) with a 16x16 register bank and a 256x16
//             data memory. One instruction accepted on every rising edge.
//  Revision : 1.0 - single-clock replacement of the two-phase pipeline
// ============================================================================
module pipe_ex2 #(
  parameter int DW     = 16,
  parameter int NREG   = 16,
  parameter int MDEPTH = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [DW-1:0]             z,
  input  logic [$clog2(NREG)-1:0]   rs1,
  input  logic [$clog2(NREG)-1:0]   rs2,
  input  logic [$clog2(NREG)-1:0]   rd,
  input  logic [3:0]                func,
  input  logic [$clog2(MDEPTH)-1:0] addr
);

  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(MDEPTH);

  // Architectural state; deliberately never reset so preloaded contents survive.
  logic [DW-1:0] regbank [NREG];
  logic [DW-1:0] mem     [MDEPTH];

  // Stage 1 (fetch) registers
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [RW-1:0] rd1;
  logic [3:0]    func1;
  logic [AW-1:0] addr1;
  logic          v1;

  // Stage 2 (execute) registers; the ALU result lives in the z port itself
  logic [RW-1:0] rd2;
  logic [AW-1:0] addr2;
  logic          v2;

  // Stage 3 (write-back) registers
  logic [DW-1:0] z3;
  logic [AW-1:0] addr3;
  logic          v3;

  // Combinational fetch operands and ALU result
  logic [DW-1:0] fetch_a;
  logic [DW-1:0] fetch_b;
  logic [DW-1:0] alu_y;

  // Operand fetch with write-before-read bypass from the stage-3 write-back.
  always_comb begin
    fetch_a = regbank[rs1];
    fetch_b = regbank[rs2];
    if (v2 && (rd2 == rs1)) fetch_a = z;
    if (v2 && (rd2 == rs2)) fetch_b = z;
  end

  // ALU: unsigned, all results truncated to DW bits.
  always_comb begin
    alu_y = '0;
    case (func1)
      4'd0:    alu_y = a + b;
      4'd1:    alu_y = a - b;
      4'd2:    alu_y = a * b;
      4'd3:    alu_y = a;
      4'd4:    alu_y = b;
      4'd5:    alu_y = a & b;
      4'd6:    alu_y = a | b;
      4'd7:    alu_y = a ^ b;
      4'd8:    alu_y = ~a;
      4'd9:    alu_y = ~b;
      4'd10:   alu_y = a >> 1;
      4'd11:   alu_y = a << 1;
      default: alu_y = '0;
    endcase
  end

  // Stage 1: latch operands and pipeline the instruction fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      rd1   <= '0;
      func1 <= '0;
      addr1 <= '0;
      v1    <= 1'b0;
    end else begin
      a     <= fetch_a;
      b     <= fetch_b;
      rd1   <= rd;
      func1 <= func;
      addr1 <= addr;
      v1    <= 1'b1;
    end
  end

  // Stage 2: register the ALU result and carry destination/address forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z     <= '0;
      rd2   <= '0;
      addr2 <= '0;
      v2    <= 1'b0;
    end else begin
      z     <= alu_y;
      rd2   <= rd1;
      addr2 <= addr1;
      v2    <= v1;
    end
  end

  // Stage 3: hold the result and store address for the memory stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z3    <= '0;
      addr3 <= '0;
      v3    <= 1'b0;
    end else begin
      z3    <= z;
      addr3 <= addr2;
      v3    <= v2;
    end
  end

  // Stage 3 register write-back; a cleared v2 discards in-flight work on reset.
  always @(posedge clk) begin
    if (v2) regbank[rd2] <= z;
  end

  // Stage 4 memory store; a cleared v3 discards in-flight work on reset.
  always @(posedge clk) begin
    if (v3) mem[addr3] <= z3;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ex2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ex2
//  Purpose  : Directed self-checking bench for pipe_ex2 with hand-computed
//             expected values.
//  Revision : 1.0 - initial bench
// ============================================================================
module tb_pipe_ex2;

  logic        clk;
  logic        rst;
  logic [15:0] z;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic [3:0]  func;
  logic [7:0]  addr;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_sweep [16];

  pipe_ex2 dut (
    .clk  (clk),
    .rst  (rst),
    .z    (z),
    .rs1  (rs1),
    .rs2  (rs2),
    .rd   (rd),
    .func (func),
    .addr (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] d,
                       input logic [3:0] f, input logic [7:0] ad);
    rs1  = r1;
    rs2  = r2;
    rd   = d;
    func = f;
    addr = ad;
  endtask

  // Harmless filler: regbank[0] = regbank[0] (which is 0), mem[0] = 0.
  task automatic nop();
    issue(4'd0, 4'd0, 4'd0, 4'd3, 8'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_sweep = '{16'h0009, 16'h0003, 16'h0012, 16'h0006, 16'h0003, 16'h0002,
                  16'h0007, 16'h0005, 16'hFFF9, 16'hFFFC, 16'h0003, 16'h000C,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    rst = 1'b1;
    nop();
    #1;
    for (int k = 0; k < 16; k++) dut.regbank[4'(k)] = 16'(k);
    dut.mem[240] = 16'hABCD;
    chk("reset_z", z, 16'h0000);
    step();
    step();
    rst = 1'b0;

    // Test 1/2/3: back-to-back issue including the bypass consumer
    issue(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);  step();  // E1
    issue(4'd3, 4'd8, 4'd12, 4'd2, 8'd126);  step();  // E2
    chk("t1_z", z, 16'd8);
    issue(4'd10, 4'd5, 4'd13, 4'd1, 8'd128); step();  // E3 (bypass)
    chk("t2a_z", z, 16'd24);
    chk("t1_rb10", dut.regbank[10], 16'd8);
    issue(4'd7, 4'd3, 4'd14, 4'd11, 8'd127); step();  // E4
    chk("t2b_z_bypass", z, 16'd3);
    chk("t2a_rb12", dut.regbank[12], 16'd24);
    chk("t1_mem125", dut.mem[125], 16'd8);
    issue(4'd10, 4'd5, 4'd15, 4'd1, 8'd129); step();  // E5
    chk("t3a_z", z, 16'd14);
    chk("t2b_rb13", dut.regbank[13], 16'd3);
    chk("t2a_mem126", dut.mem[126], 16'd24);

    // Test 4: producer at E6, stale consumer at E7, wrap at E8
    issue(4'd1, 4'd2, 4'd9, 4'd0, 8'd200);   step();  // E6
    chk("t3b_z", z, 16'd3);
    chk("t3a_rb14", dut.regbank[14], 16'd14);
    chk("t2b_mem128", dut.mem[128], 16'd3);
    issue(4'd9, 4'd0, 4'd11, 4'd3, 8'd201);  step();  // E7
    chk("t4_prod_z", z, 16'd3);
    chk("t3b_rb15", dut.regbank[15], 16'd3);
    chk("t3a_mem127", dut.mem[127], 16'd14);
    issue(4'd3, 4'd5, 4'd2, 4'd1, 8'd202);   step();  // E8
    chk("t4_stale_read_z", z, 16'd9);
    chk("t3b_mem129", dut.mem[129], 16'd3);
    chk("t4_prod_rb9", dut.regbank[9], 16'd3);

    // Test 5: func sweep with A=6, B=3
    for (int f = 0; f < 16; f++) begin
      issue(4'd6, 4'd3, 4'd8, 4'(f), 8'(210 + f));
      step();
      if (f == 0) chk("t4_wrap_z", z, 16'hFFFE);
      else        chk($sformatf("sweep_f%0d", f - 1), z, exp_sweep[f-1]);
    end
    nop();
    step();
    chk("sweep_f15", z, exp_sweep[15]);
    step();
    step();
    chk("t4_wrap_mem202", dut.mem[202], 16'hFFFE);
    chk("sweep_mem218", dut.mem[218], 16'hFFF9);
    chk("sweep_mem225", dut.mem[225], 16'h0000);

    // Test 6: reset between execute and write-back of an instruction
    issue(4'd4, 4'd5, 4'd7, 4'd0, 8'd240);   step();
    nop();                                   step();
    chk("t6_pre_reset_z", z, 16'd9);
    rst = 1'b1;
    #1;
    chk("t6_async_z", z, 16'h0000);
    chk("t6_rb7_in_reset", dut.regbank[7], 16'd7);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    step();
    step();
    chk("t6_rb7_kept", dut.regbank[7], 16'd7);
    chk("t6_mem240_kept", dut.mem[240], 16'hABCD);
    chk("t6_rb3_kept", dut.regbank[3], 16'd3);
    chk("t6_rb5_kept", dut.regbank[5], 16'd5);
    chk("t6_z_after", z, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
